// File: rtl/change_dispense_sequencer.sv
// Coin acceptor and change sequencer: credits inserted coins, vends at PRICE, then pays
// change or refunds greedily (quarter/dime/nickel) from tracked tube inventories.
module change_dispense_sequencer #(
  parameter int PRICE       = 13,
  parameter int CREDIT_W    = 6,
  parameter int NICKEL_CAP  = 10,
  parameter int DIME_CAP    = 5,
  parameter int QUARTER_CAP = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                dollar,
  input  logic                refund,
  output logic                vend,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                quarter_out,
  output logic                busy,
  output logic                short,
  output logic [CREDIT_W-1:0] credit
);

  localparam int NW    = $clog2(NICKEL_CAP + 1);
  localparam int DW    = $clog2(DIME_CAP + 1);
  localparam int QW    = $clog2(QUARTER_CAP + 1);
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int SUM_W = CREDIT_W + 5;

  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
  localparam logic [CREDIT_W-1:0] CREDIT_0   = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] Q_VAL      = CREDIT_W'(3'd5);
  localparam logic [CREDIT_W-1:0] D_VAL      = CREDIT_W'(3'd2);
  localparam logic [CREDIT_W-1:0] N_VAL      = CREDIT_W'(3'd1);
  localparam logic [NW-1:0]       N_CAP      = NW'(NICKEL_CAP);
  localparam logic [DW-1:0]       D_CAP      = DW'(DIME_CAP);
  localparam logic [QW-1:0]       Q_CAP      = QW'(QUARTER_CAP);
  localparam logic [GW-1:0]       GAP_LAST   = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEND   = 3'd1,
    SELECT = 3'd2,
    PULSE  = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t                state_r;
  logic [CREDIT_W-1:0]   credit_r;
  logic [NW-1:0]         ninv_r;
  logic [DW-1:0]         dinv_r;
  logic [QW-1:0]         qinv_r;
  logic [GW-1:0]         gap_cnt_r;
  logic                  vend_r;
  logic                  nickel_out_r;
  logic                  dime_out_r;
  logic                  quarter_out_r;
  logic                  short_r;

  logic [SUM_W-1:0]      coin_val_s;
  logic [SUM_W-1:0]      sum_s;
  logic [CREDIT_W-1:0]   credit_acc_s;
  logic [NW-1:0]         ninv_acc_s;
  logic [DW-1:0]         dinv_acc_s;
  logic [QW-1:0]         qinv_acc_s;
  logic                  coin_seen_s;
  logic                  pick_q_s;
  logic                  pick_d_s;
  logic                  pick_n_s;

  // Same-cycle pulses are summed; the wide sum lets saturation be detected cleanly.
  assign coin_val_s   = (nickel  ? SUM_W'(5'd1)  : SUM_W'(5'd0))
                      + (dime    ? SUM_W'(5'd2)  : SUM_W'(5'd0))
                      + (quarter ? SUM_W'(5'd5)  : SUM_W'(5'd0))
                      + (dollar  ? SUM_W'(5'd20) : SUM_W'(5'd0));
  assign sum_s        = {5'b00000, credit_r} + coin_val_s;
  assign credit_acc_s = (sum_s > {5'b00000, CREDIT_MAX}) ? CREDIT_MAX : sum_s[CREDIT_W-1:0];
  assign coin_seen_s  = nickel | dime | quarter | dollar;

  assign ninv_acc_s = (nickel  && (ninv_r < N_CAP)) ? ninv_r + NW'(1'b1) : ninv_r;
  assign dinv_acc_s = (dime    && (dinv_r < D_CAP)) ? dinv_r + DW'(1'b1) : dinv_r;
  assign qinv_acc_s = (quarter && (qinv_r < Q_CAP)) ? qinv_r + QW'(1'b1) : qinv_r;

  assign pick_q_s = (credit_r >= Q_VAL) && (qinv_r != {QW{1'b0}});
  assign pick_d_s = (credit_r >= D_VAL) && (dinv_r != {DW{1'b0}});
  assign pick_n_s = (credit_r >= N_VAL) && (ninv_r != {NW{1'b0}});

  // Sequencer: coin accept, vend, greedy payout with gap spacing; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      credit_r      <= CREDIT_0;
      ninv_r        <= N_CAP;
      dinv_r        <= D_CAP;
      qinv_r        <= Q_CAP;
      gap_cnt_r     <= {GW{1'b0}};
      vend_r        <= 1'b0;
      nickel_out_r  <= 1'b0;
      dime_out_r    <= 1'b0;
      quarter_out_r <= 1'b0;
      short_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ninv_r <= ninv_acc_s;
          dinv_r <= dinv_acc_s;
          qinv_r <= qinv_acc_s;
          if (coin_seen_s) begin
            short_r <= 1'b0;
          end
          // Vend is judged on the registered credit, so it takes priority over refund.
          if (credit_r >= PRICE_C) begin
            state_r  <= VEND;
            vend_r   <= 1'b1;
            credit_r <= credit_acc_s - PRICE_C;
          end else if (refund && (credit_r != CREDIT_0)) begin
            state_r  <= SELECT;
            credit_r <= credit_acc_s;
          end else begin
            credit_r <= credit_acc_s;
          end
        end
        VEND: begin
          vend_r  <= 1'b0;
          state_r <= (credit_r != CREDIT_0) ? SELECT : IDLE;
        end
        SELECT: begin
          if (pick_q_s) begin
            quarter_out_r <= 1'b1;
            credit_r      <= credit_r - Q_VAL;
            qinv_r        <= qinv_r - QW'(1'b1);
            state_r       <= PULSE;
          end else if (pick_d_s) begin
            dime_out_r <= 1'b1;
            credit_r   <= credit_r - D_VAL;
            dinv_r     <= dinv_r - DW'(1'b1);
            state_r    <= PULSE;
          end else if (pick_n_s) begin
            nickel_out_r <= 1'b1;
            credit_r     <= credit_r - N_VAL;
            ninv_r       <= ninv_r - NW'(1'b1);
            state_r      <= PULSE;
          end else begin
            // Nothing fits: keep the credit so a later refund can retry.
            state_r <= IDLE;
            short_r <= (credit_r != CREDIT_0) ? 1'b1 : short_r;
          end
        end
        PULSE: begin
          nickel_out_r  <= 1'b0;
          dime_out_r    <= 1'b0;
          quarter_out_r <= 1'b0;
          gap_cnt_r     <= {GW{1'b0}};
          state_r       <= GAP;
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= SELECT;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1'b1);
          end
        end
        default: begin
          state_r       <= IDLE;
          vend_r        <= 1'b0;
          nickel_out_r  <= 1'b0;
          dime_out_r    <= 1'b0;
          quarter_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign vend        = vend_r;
  assign nickel_out  = nickel_out_r;
  assign dime_out    = dime_out_r;
  assign quarter_out = quarter_out_r;
  assign short       = short_r;
  assign credit      = credit_r;
  assign busy        = (state_r != IDLE);

endmodule
